processing_element_pipe: RTL and testbench

Parametrised successor of the halved Pair-HMM processing element: one systolic-array cell computing the M/I/D forward recurrences in unsigned saturating fixed point with a fixed, parameter-set latency. It adds an explicit start/busy/done FSM, back-to-back advance+start with own-state bypass, row-start state clearing, and an optional likelihood accumulator for the last PE in the array.

---
 rtl/processing_element_pipe.sv | 195 +++++++++++++++++++
 tb/tb_processing_element_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/processing_element_pipe.sv
// rtl/processing_element_pipe.sv - Pair-HMM systolic cell, saturating fixed point, fixed latency
// Two-stage datapath (products/sums, then final add/mul) behind an IDLE/BUSY/DONE handshake.
module processing_element_pipe #(
   parameter int WIDTH   = 32,
   parameter int FRAC    = 30,
   parameter int LATENCY = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 advance,
   input  logic                 set_tb_special,
   input  logic                 accum_en,
   input  logic                 clear_state,
   input  logic [6*WIDTH-1:0]   probs,
   input  logic [WIDTH-1:0]     prior,
   input  logic [5*WIDTH-1:0]   vals_in,
   output logic [5*WIDTH-1:0]   vals_out,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     accum_out
);

   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic logic [WIDTH-1:0] f_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] v_p;
      v_p = ({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}) >> FRAC;
      if (|v_p[2*WIDTH-1:WIDTH]) return {WIDTH{1'b1}};
      return v_p[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] f_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH:0] v_s;
      v_s = {1'b0, a} + {1'b0, b};
      if (v_s[WIDTH]) return {WIDTH{1'b1}};
      return v_s[WIDTH-1:0];
   endfunction

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CW-1:0]        r_cnt;
   logic                 w_accept;
   logic                 w_commit;
   logic                 w_clear;

   logic [6*WIDTH-1:0]   r_probs;
   logic [WIDTH-1:0]     r_prior;
   logic [5*WIDTH-1:0]   r_vin;
   logic                 r_tb_sel;
   logic [5*WIDTH-1:0]   r_own;
   logic [5*WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]     r_accum;

   logic [WIDTH-1:0]     r_p_mi_m;
   logic [WIDTH-1:0]     r_p_ii_i;
   logic [WIDTH-1:0]     r_p_md_m;
   logic [WIDTH-1:0]     r_p_dd_d;
   logic [WIDTH-1:0]     r_s_id;
   logic [WIDTH-1:0]     r_p_mm_m;
   logic [WIDTH-1:0]     r_s_m;

   logic [WIDTH-1:0]     w_a_mm, w_a_mi, w_a_md, w_a_ii, w_a_dd, w_a_dm;
   logic [WIDTH-1:0]     w_in_m, w_in_i, w_in_d, w_in_tb;
   logic [WIDTH-1:0]     w_own_m, w_own_i, w_own_ta, w_own_tb;
   logic [WIDTH-1:0]     w_res_m, w_res_i, w_res_d, w_res_ta, w_res_tb;
   logic [WIDTH-1:0]     w_com_m, w_com_i;

   assign w_a_mm   = r_probs[6*WIDTH-1:5*WIDTH];
   assign w_a_mi   = r_probs[5*WIDTH-1:4*WIDTH];
   assign w_a_md   = r_probs[4*WIDTH-1:3*WIDTH];
   assign w_a_ii   = r_probs[3*WIDTH-1:2*WIDTH];
   assign w_a_dd   = r_probs[2*WIDTH-1:WIDTH];
   assign w_a_dm   = r_probs[WIDTH-1:0];

   // Neighbour t_a is not used by the recurrence.
   assign w_in_m   = r_vin[5*WIDTH-1:4*WIDTH];
   assign w_in_i   = r_vin[4*WIDTH-1:3*WIDTH];
   assign w_in_d   = r_vin[3*WIDTH-1:2*WIDTH];
   assign w_in_tb  = r_vin[WIDTH-1:0];

   assign w_own_m  = r_own[5*WIDTH-1:4*WIDTH];
   assign w_own_i  = r_own[4*WIDTH-1:3*WIDTH];
   assign w_own_ta = r_own[2*WIDTH-1:WIDTH];
   assign w_own_tb = r_own[WIDTH-1:0];

   assign w_res_i  = f_add(r_p_mi_m, r_p_ii_i);
   assign w_res_d  = f_add(r_p_md_m, r_p_dd_d);
   assign w_res_ta = f_mul(r_s_id, w_a_dm);
   assign w_res_tb = r_p_mm_m;
   assign w_res_m  = f_mul(r_s_m, r_prior);

   assign w_com_m  = r_result[5*WIDTH-1:4*WIDTH];
   assign w_com_i  = r_result[4*WIDTH-1:3*WIDTH];

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (clear_state) begin
               w_clear = 1'b1;
            end else if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_cnt == '0) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            if (advance) begin
               w_commit = 1'b1;
               if (start) begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_BUSY;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_probs  <= '0;
         r_prior  <= '0;
         r_vin    <= '0;
         r_tb_sel <= 1'b0;
         r_own    <= '0;
         r_result <= '0;
         r_accum  <= '0;
         r_p_mi_m <= '0;
         r_p_ii_i <= '0;
         r_p_md_m <= '0;
         r_p_dd_d <= '0;
         r_s_id   <= '0;
         r_p_mm_m <= '0;
         r_s_m    <= '0;
      end else begin
         if (w_accept) begin
            r_probs  <= probs;
            r_prior  <= prior;
            r_vin    <= vals_in;
            r_tb_sel <= set_tb_special;
            r_cnt    <= CW'(LATENCY - 1);
         end else if (r_state == S_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end

         // Stage one reads r_own, which a bypassed commit has already updated.
         if (r_state == S_BUSY) begin
            r_p_mi_m <= f_mul(w_a_mi, w_own_m);
            r_p_ii_i <= f_mul(w_a_ii, w_own_i);
            r_p_md_m <= f_mul(w_a_md, w_in_m);
            r_p_dd_d <= f_mul(w_a_dd, w_in_d);
            r_s_id   <= f_add(w_in_i, w_in_d);
            r_p_mm_m <= f_mul(w_a_mm, w_in_m);
            r_s_m    <= f_add(w_own_ta, r_tb_sel ? w_in_tb : w_own_tb);
            if (r_cnt == '0)
               r_result <= {w_res_m, w_res_i, w_res_d, w_res_ta, w_res_tb};
         end

         if (w_clear) begin
            r_own   <= '0;
            r_accum <= '0;
         end else if (w_commit) begin
            r_own <= r_result;
            if (accum_en) r_accum <= f_add(r_accum, f_add(w_com_m, w_com_i));
         end
      end
   end

   assign vals_out  = r_own;
   assign accum_out = r_accum;
   assign busy      = (r_state == S_BUSY);
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_processing_element_pipe.sv
// tb/tb_processing_element_pipe.sv - directed self-checking bench for processing_element_pipe
module tb_processing_element_pipe;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic           advance;
   logic           set_tb_special;
   logic           accum_en;
   logic           clear_state;
   logic [6*W-1:0] probs;
   logic [W-1:0]   prior;
   logic [5*W-1:0] vals_in;
   logic [5*W-1:0] vals_out;
   logic           busy;
   logic           done;
   logic [W-1:0]   accum_out;

   int checks   = 0;
   int failures = 0;

   processing_element_pipe #(.WIDTH(W), .FRAC(14), .LATENCY(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .advance        (advance),
      .set_tb_special (set_tb_special),
      .accum_en       (accum_en),
      .clear_state    (clear_state),
      .probs          (probs),
      .prior          (prior),
      .vals_in        (vals_in),
      .vals_out       (vals_out),
      .busy           (busy),
      .done           (done),
      .accum_out      (accum_out)
   );

   always #5 clk = ~clk;

   function automatic logic [5*W-1:0] pack5(input logic [W-1:0] m, input logic [W-1:0] i,
                                             input logic [W-1:0] d, input logic [W-1:0] ta,
                                             input logic [W-1:0] tb);
      return {m, i, d, ta, tb};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk(tag, 80'(n), 80'd4);
   endtask

   // Start a cell from IDLE, commit it with accumulation, check the committed state.
   task automatic do_cell(input string tag, input logic [5*W-1:0] exp_v, input logic [W-1:0] exp_a);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done({tag, "_lat"});
      accum_en = 1'b1;
      advance  = 1'b1;
      tick();
      advance  = 1'b0;
      accum_en = 1'b0;
      chk({tag, "_vals"}, 80'(vals_out), 80'(exp_v));
      chk({tag, "_accum"}, 80'(accum_out), 80'(exp_a));
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; advance = 1'b0; set_tb_special = 1'b0;
      accum_en = 1'b0; clear_state = 1'b0;
      probs = '0; prior = '0; vals_in = '0;
      tick();
      tick();
      reset = 1'b1;
      chk("rst_busy", 80'(busy), 80'd0);
      chk("rst_done", 80'(done), 80'd0);
      chk("rst_vals", 80'(vals_out), 80'd0);
      chk("rst_accum", 80'(accum_out), 80'd0);

      // Basic cell: latency and recurrence from zero own state.
      probs   = {6{16'h2000}};
      prior   = 16'h4000;
      vals_in = pack5(16'h4000, 16'h0, 16'h0, 16'h0, 16'h4000);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_busy_e0", 80'(busy), 80'd1);
      tick(); tick(); tick();
      chk("t1_busy_e3", 80'(busy), 80'd1);
      chk("t1_done_e3", 80'(done), 80'd0);
      tick();
      chk("t1_done_e4", 80'(done), 80'd1);
      chk("t1_busy_e4", 80'(busy), 80'd0);
      chk("t1_hold_vals", 80'(vals_out), 80'd0);
      advance = 1'b1;
      tick();
      advance = 1'b0;
      chk("t1_vals", 80'(vals_out), 80'(pack5(16'h0, 16'h0, 16'h2000, 16'h0, 16'h2000)));
      chk("t1_done_clr", 80'(done), 80'd0);

      // set_tb_special, then commit with advance+start (bypass).
      set_tb_special = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      set_tb_special = 1'b0;
      wait_done("t2_lat");
      accum_en = 1'b1;
      advance  = 1'b1;
      start    = 1'b1;
      tick();
      advance = 1'b0; start = 1'b0; accum_en = 1'b0;
      chk("t2_vals", 80'(vals_out), 80'(pack5(16'h4000, 16'h0, 16'h2000, 16'h0, 16'h2000)));
      chk("t2_accum", 80'(accum_out), 80'h4000);
      chk("b2b_busy", 80'(busy), 80'd1);
      wait_done("b2b_lat");
      accum_en = 1'b1;
      advance  = 1'b1;
      tick();
      advance = 1'b0; accum_en = 1'b0;
      chk("b2b_vals", 80'(vals_out), 80'(pack5(16'h2000, 16'h2000, 16'h2000, 16'h0, 16'h2000)));
      chk("b2b_accum", 80'(accum_out), 80'h8000);

      // Ignored controls: start/advance in BUSY, clear_state and lone start in DONE.
      set_tb_special = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      set_tb_special = 1'b0;
      probs   = {6{16'hFFFF}};
      vals_in = {5{16'hFFFF}};
      start   = 1'b1;
      advance = 1'b1;
      tick();
      start = 1'b0; advance = 1'b0;
      chk("ign_busy", 80'(busy), 80'd1);
      chk("ign_vals_busy", 80'(vals_out), 80'(pack5(16'h2000, 16'h2000, 16'h2000, 16'h0, 16'h2000)));
      tick(); tick();
      chk("ign_done_e3", 80'(done), 80'd0);
      tick();
      chk("ign_done_e4", 80'(done), 80'd1);
      clear_state = 1'b1;
      start       = 1'b1;
      tick();
      clear_state = 1'b0; start = 1'b0;
      chk("ign_clr_done", 80'(done), 80'd1);
      chk("ign_clr_vals", 80'(vals_out), 80'(pack5(16'h2000, 16'h2000, 16'h2000, 16'h0, 16'h2000)));
      chk("ign_clr_accum", 80'(accum_out), 80'h8000);
      accum_en = 1'b1;
      advance  = 1'b1;
      tick();
      advance = 1'b0; accum_en = 1'b0;
      chk("ign_vals", 80'(vals_out), 80'(pack5(16'h4000, 16'h2000, 16'h2000, 16'h0, 16'h2000)));
      chk("ign_accum", 80'(accum_out), 80'hE000);

      // clear_state beats start in IDLE.
      clear_state = 1'b1;
      start       = 1'b1;
      tick();
      clear_state = 1'b0; start = 1'b0;
      chk("clr_busy", 80'(busy), 80'd0);
      chk("clr_vals", 80'(vals_out), 80'd0);
      chk("clr_accum", 80'(accum_out), 80'd0);
      tick();
      chk("clr_busy2", 80'(busy), 80'd0);

      // Reset mid-computation.
      probs   = {6{16'h2000}};
      vals_in = pack5(16'h4000, 16'h0, 16'h0, 16'h0, 16'h4000);
      set_tb_special = 1'b1;
      do_cell("pre", pack5(16'h4000, 16'h0, 16'h2000, 16'h0, 16'h2000), 16'h4000);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      set_tb_special = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mrst_busy", 80'(busy), 80'd0);
      chk("mrst_done", 80'(done), 80'd0);
      chk("mrst_vals", 80'(vals_out), 80'd0);
      chk("mrst_accum", 80'(accum_out), 80'd0);
      advance = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      advance = 1'b0;
      chk("mrst_adv_vals", 80'(vals_out), 80'd0);
      chk("mrst_adv_done", 80'(done), 80'd0);

      // Saturation of mul, add and the accumulator.
      probs   = {16'hFFFF, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
      prior   = 16'h4000;
      vals_in = pack5(16'hFFFF, 16'hC000, 16'hC000, 16'h0, 16'h0);
      do_cell("satA", pack5(16'h0, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'h0);
      do_cell("satB", pack5(16'hFFFF, 16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFF);
      do_cell("satC", pack5(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 16'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
